// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for lock with bounded
// retries, qualifies lock stability, then releases the system reset. Re-sequences on lock loss.
module pll_reset_ctrl #(
    parameter int RST_PULSE_CYCLES   = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               locked,
    input  logic                               restart,
    output logic                               pll_rst,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [7:0]                         loss_cnt
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P   = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_P) + 1;

    // Each state exits on the edge where cnt holds its last in-state value, so a state
    // entered at edge e is left at edge e+N.
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t               state_reg, state_next;
    logic [1:0]           sync_reg;
    logic                 lock_s;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [RETRY_W-1:0]   retry_reg, retry_next;
    logic [7:0]           loss_reg, loss_next;
    logic                 pll_rst_reg, pll_rst_next;
    logic                 sys_rst_reg, sys_rst_next;
    logic                 ready_reg, ready_next;
    logic                 fault_reg, fault_next;

    assign lock_s = sync_reg[1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_reg    <= '0;
            state_reg   <= S_RESET;
            cnt_reg     <= '0;
            retry_reg   <= '0;
            loss_reg    <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], locked};
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            retry_reg   <= retry_next;
            loss_reg    <= loss_next;
            pll_rst_reg <= pll_rst_next;
            sys_rst_reg <= sys_rst_next;
            ready_reg   <= ready_next;
            fault_reg   <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;

        case (state_reg)
            S_RESET: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock beats a timeout landing on the same edge.
                if (lock_s) begin
                    state_next = S_STABLE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    retry_next = retry_reg + RETRY_W'(1);
                    state_next = (retry_next == RETRY_MAX) ? S_FAULT : S_RESET;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_next = S_WAIT_LOCK;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = S_RUN;
                    retry_next = '0;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_next = S_RESET;
                    if (loss_reg != 8'hFF) begin
                        loss_next = loss_reg + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_RESET;
            end
        endcase

        // restart overrides every transition but still lets a coincident lock loss count.
        if (restart) begin
            state_next = S_RESET;
            retry_next = '0;
        end

        if (restart || (state_next != state_reg)) begin
            cnt_next = '0;
        end else if (cnt_reg != '1) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else begin
            cnt_next = cnt_reg;
        end

        pll_rst_next = (state_next == S_RESET) || (state_next == S_FAULT);
        sys_rst_next = (state_next != S_RUN);
        ready_next   = (state_next == S_RUN);
        fault_next   = (state_next == S_FAULT);
    end

    assign pll_rst   = pll_rst_reg;
    assign sys_rst   = sys_rst_reg;
    assign ready     = ready_reg;
    assign fault     = fault_reg;
    assign retry_cnt = retry_reg;
    assign loss_cnt  = loss_reg;

endmodule
